// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared constants for the instruction fetch front end
package fetch_pkg;

  localparam int INST_W  = 32;
  localparam int PC_STEP = 4;

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - flop-array synchronous FIFO with clear, count and head output
module fetch_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       clear,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [WIDTH-1:0]           head,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push && !clear) mem[wr_ptr] <= push_data;
  end

  assign head = mem[rd_ptr];

endmodule

// File: rtl/fetch_queue_unit.sv
// rtl/fetch_queue_unit.sv - decoupled fetch front end: PC, credits, drop counter, redirect
module fetch_queue_unit
  import fetch_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       imem_req_valid,
  input  logic                       imem_req_ready,
  output logic [XLEN-1:0]            imem_req_addr,
  input  logic                       imem_rsp_valid,
  input  logic [INST_W-1:0]          imem_rsp_data,
  output logic                       inst_valid,
  input  logic                       inst_ready,
  output logic [INST_W-1:0]          inst,
  output logic [XLEN-1:0]            inst_pc,
  output logic [XLEN-1:0]            inst_pc_plus4,
  output logic [$clog2(DEPTH+1)-1:0] occupancy
);

  localparam int           CW      = $clog2(DEPTH+1);
  localparam logic [CW:0]  DEPTH_C = (CW+1)'(DEPTH);
  localparam logic [XLEN-1:0] STEP = XLEN'(PC_STEP);

  typedef struct packed {
    logic [INST_W-1:0] inst;
    logic [XLEN-1:0]   pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc;
  logic [XLEN-1:0] rsp_pc;
  logic [XLEN-1:0] redirect_base;
  logic [CW-1:0]   count;
  logic [CW-1:0]   outstanding;
  logic [CW-1:0]   drop_cnt;
  logic [CW:0]     credit_used;
  logic            running;
  logic            req_fire;
  logic            rsp_fire;
  logic            push;
  logic            pop;
  entry_t          push_entry;
  entry_t          head_entry;

  assign redirect_base = redirect_pc & ~XLEN'(3);

  // Credits count both buffered entries and in-flight requests, so the queue can never overflow.
  assign credit_used    = {1'b0, count} + {1'b0, outstanding};
  assign imem_req_valid = running & ~redirect_valid & (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc;
  assign req_fire       = imem_req_valid & imem_req_ready;
  assign rsp_fire       = imem_rsp_valid;

  assign push       = rsp_fire & ~redirect_valid & (drop_cnt == '0);
  assign inst_valid = (count != '0) & ~redirect_valid;
  assign pop        = inst_valid & inst_ready;
  assign push_entry = '{inst: imem_rsp_data, pc: rsp_pc};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      running     <= 1'b0;
      fetch_pc    <= RESET_PC;
      rsp_pc      <= RESET_PC;
      outstanding <= '0;
      drop_cnt    <= '0;
    end else begin
      running <= 1'b1;
      case ({req_fire, rsp_fire})
        2'b10:   outstanding <= outstanding + 1'b1;
        2'b01:   outstanding <= outstanding - 1'b1;
        default: outstanding <= outstanding;
      endcase
      if (redirect_valid) begin
        fetch_pc <= redirect_base;
        rsp_pc   <= redirect_base;
        // Everything still in flight after this cycle belongs to the abandoned path.
        drop_cnt <= outstanding - CW'(rsp_fire);
      end else begin
        if (req_fire) fetch_pc <= fetch_pc + STEP;
        if (push)     rsp_pc   <= rsp_pc + STEP;
        if (rsp_fire && (drop_cnt != '0)) drop_cnt <= drop_cnt - 1'b1;
      end
    end
  end

  fetch_fifo #(
    .WIDTH ($bits(entry_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .clear     (redirect_valid),
    .push      (push),
    .push_data (push_entry),
    .pop       (pop),
    .head      (head_entry),
    .count     (count)
  );

  assign inst          = inst_valid ? head_entry.inst : '0;
  assign inst_pc       = inst_valid ? head_entry.pc : '0;
  assign inst_pc_plus4 = inst_valid ? (head_entry.pc + STEP) : '0;
  assign occupancy     = count;

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
                                 !(push && (count == CW'(DEPTH))));

endmodule
